// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP inference core.
//   - Default fixed-point geometry (P_*) used as parameter defaults.
//   - Derived default widths: data (P_DW), weight (P_WW), accumulator (P_ACCW).
//   - FSM state encoding.
//   - Saturation and ReLU helpers. They work on a 64-bit signed carrier so
//     one helper serves every parameterisation; callers narrow the result.
package mlp_pkg;

  localparam int P_M  = 3;
  localparam int P_N  = 2;
  localparam int P_QM = 3;
  localparam int P_QN = 5;
  localparam int P_WM = 3;
  localparam int P_WN = 5;

  localparam int P_DW   = P_QM + P_QN;
  localparam int P_WW   = P_WM + P_WN;
  localparam int P_ACCW = P_DW + P_WW + $clog2(P_N) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_ACT  = 2'd2,
    ST_DONE = 2'd3
  } mlp_state_e;

  // Clamp v into the signed range of a dw-bit number.
  function automatic logic signed [63:0] sat_q(input logic signed [63:0] v,
                                               input int dw);
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (dw - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (dw - 1));
    if (v > mx)      return mx;
    else if (v < mn) return mn;
    return v;
  endfunction

  function automatic logic signed [63:0] relu_q(input logic signed [63:0] v);
    return v[63] ? 64'sd0 : v;
  endfunction

endpackage

// File: rtl/mlp_n_neuron_mac.sv
// Single neuron: serial multiply-accumulate plus bias/saturate/ReLU.
//   clk, nrst  : clock, async active-low reset
//   clr_i      : zero the accumulator (wins over acc_en_i)
//   acc_en_i   : add act_i*wt_i to the accumulator this cycle
//   act_i      : activation operand (signed Q(QM.QN))
//   wt_i       : weight operand (signed Q(WM.WN))
//   bias_i     : bias for the current layer (signed Q(QM.QN))
//   y_o        : ((acc >>> WN) + bias), saturated, ReLU'd; combinational
//                from the accumulator so it is valid in the ACT cycle.
module mlp_neuron_mac
  import mlp_pkg::*;
#(
  parameter int DW   = P_DW,
  parameter int WW   = P_WW,
  parameter int ACCW = P_ACCW,
  parameter int WN   = P_WN
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 clr_i,
  input  logic                 acc_en_i,
  input  logic signed [DW-1:0] act_i,
  input  logic signed [WW-1:0] wt_i,
  input  logic signed [DW-1:0] bias_i,
  output logic        [DW-1:0] y_o
);

  logic signed [DW+WW-1:0] prod;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic signed [ACCW-1:0]  sum;

  assign prod = act_i * wt_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)         acc_d = '0;
    else if (acc_en_i) acc_d = acc_q + ACCW'(prod);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  // Drop the weight fraction bits to return to the data Q format.
  assign sum = (acc_q >>> WN) + ACCW'(bias_i);
  assign y_o = DW'(relu_q(sat_q(64'(sum), DW)));

endmodule

// File: rtl/mlp_n_neuron.sv
// Fixed-point MLP inference core: M layers (M-1 weighted), N neurons each.
//   clk, nrst    : clock, async active-low reset
//   init         : start / restart a run (honoured in every state)
//   initial_flag : load x
//   weight_flag  : load w and b
//   x            : input vector, N x DW signed
//   w            : weights w[l][j][k] (layer, neuron, input)
//   b            : biases b[l][j]
//   outputs      : registered neuron-0 result of the final layer
// Each layer takes N MAC cycles plus one ACT cycle; the result lands
// (M-1)*(N+1) edges after the edge that samples init.
module mlp_n_neuron
  import mlp_pkg::*;
#(
  parameter int M  = P_M,
  parameter int N  = P_N,
  parameter int QM = P_QM,
  parameter int QN = P_QN,
  parameter int WM = P_WM,
  parameter int WN = P_WN
) (
  input  logic                                     clk,
  input  logic                                     nrst,
  input  logic                                     init,
  input  logic                                     initial_flag,
  input  logic                                     weight_flag,
  input  logic [N-1:0][QM+QN-1:0]                  x,
  input  logic [M-2:0][N-1:0][N-1:0][WM+WN-1:0]    w,
  input  logic [M-2:0][N-1:0][QM+QN-1:0]           b,
  output logic signed [QM+QN-1:0]                  outputs
);

  localparam int DW   = QM + QN;
  localparam int WW   = WM + WN;
  localparam int ACCW = DW + WW + $clog2(N) + 1;
  localparam int LW   = (M > 2) ? $clog2(M - 1) : 1;
  localparam int KW   = (N > 1) ? $clog2(N) : 1;

  // Operand registers
  logic [N-1:0][DW-1:0]                x_q;
  logic [M-2:0][N-1:0][N-1:0][WW-1:0]  w_q;
  logic [M-2:0][N-1:0][DW-1:0]         b_q;
  logic [N-1:0][DW-1:0]                h_q;   // previous layer's results
  logic [DW-1:0]                       out_q;

  mlp_state_e    state_q, state_d;
  logic [LW-1:0] l_q, l_d;
  logic [KW-1:0] k_q, k_d;

  logic clr, acc_en, h_ld, out_ld;
  logic [DW-1:0]        act_k;
  logic [N-1:0][DW-1:0] y;

  // Loads are independent of the FSM so the host can stage operands anytime.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x_q <= '0;
      w_q <= '0;
      b_q <= '0;
    end else begin
      if (initial_flag) x_q <= x;
      if (weight_flag) begin
        w_q <= w;
        b_q <= b;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      l_q     <= '0;
      k_q     <= '0;
      h_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      k_q     <= k_d;
      if (h_ld)   h_q   <= y;
      if (out_ld) out_q <= y[0];
    end
  end

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    k_d     = k_q;
    clr     = 1'b0;
    acc_en  = 1'b0;
    h_ld    = 1'b0;
    out_ld  = 1'b0;
    case (state_q)
      ST_MAC: begin
        acc_en = 1'b1;
        if (k_q == KW'(N - 1)) begin
          k_d     = '0;
          state_d = ST_ACT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_ACT: begin
        h_ld = 1'b1;
        if (l_q == LW'(M - 2)) begin
          // Final layer: neuron 0 goes straight to the output register
          // on the same edge that enters DONE.
          out_ld  = 1'b1;
          state_d = ST_DONE;
        end else begin
          l_d     = l_q + 1'b1;
          clr     = 1'b1;
          state_d = ST_MAC;
        end
      end
      default: ;
    endcase
    // init overrides everything, including a run in progress.
    if (init) begin
      state_d = ST_MAC;
      l_d     = '0;
      k_d     = '0;
      clr     = 1'b1;
      acc_en  = 1'b0;
      h_ld    = 1'b0;
      out_ld  = 1'b0;
    end
  end

  // The same activation element feeds every neuron in a given MAC cycle.
  assign act_k = (l_q == '0) ? x_q[k_q] : h_q[k_q];

  for (genvar j = 0; j < N; j++) begin : g_neu
    mlp_neuron_mac #(
      .DW  (DW),
      .WW  (WW),
      .ACCW(ACCW),
      .WN  (WN)
    ) u_mac (
      .clk     (clk),
      .nrst    (nrst),
      .clr_i   (clr),
      .acc_en_i(acc_en),
      .act_i   (act_k),
      .wt_i    (w_q[l_q][j][k_q]),
      .bias_i  (b_q[l_q][j]),
      .y_o     (y[j])
    );
  end

  assign outputs = out_q;

endmodule

// File: tb/tb_mlp_n_neuron.sv
module tb_mlp_n_neuron;

  localparam int M = 3;
  localparam int N = 2;
  localparam int WN = 5;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic init = 1'b0;
  logic initial_flag = 1'b0;
  logic weight_flag = 1'b0;
  logic [N-1:0][7:0]               x = '0;
  logic [M-2:0][N-1:0][N-1:0][7:0] w = '0;
  logic [M-2:0][N-1:0][7:0]        b = '0;
  logic signed [7:0]               outputs;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp = 8'h00;

  always #5 clk = ~clk;

  mlp_n_neuron dut (
    .clk(clk), .nrst(nrst), .init(init), .initial_flag(initial_flag),
    .weight_flag(weight_flag), .x(x), .w(w), .b(b), .outputs(outputs)
  );

  // Reference MLP straight from the behavioural description.
  function automatic int model(input int xa[N], input int wa[M-1][N][N],
                               input int ba[M-1][N]);
    int act[N];
    int nxt[N];
    int acc, v;
    act = xa;
    for (int l = 0; l < M - 1; l++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) acc += act[k] * wa[l][j][k];
        v = (acc >>> WN) + ba[l][j];
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        if (v < 0) v = 0;
        nxt[j] = v;
      end
      act = nxt;
    end
    return act[0];
  endfunction

  // Drive one cycle of strobes with uniform operand values; returns 1ns
  // after the sampling edge.
  task automatic drive(input bit di, input bit dx, input bit dw,
                       input logic [7:0] xv, input logic [7:0] wv,
                       input logic [7:0] bv);
    @(negedge clk);
    x = {N{xv}};
    w = {((M-1)*N*N){wv}};
    b = {((M-1)*N){bv}};
    init = di; initial_flag = dx; weight_flag = dw;
    @(posedge clk); #1;
    init = 1'b0; initial_flag = 1'b0; weight_flag = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (outputs !== 8'h00) begin
      bad++; $display("FAIL reset_out got=%h exp=00", outputs);
    end
    @(negedge clk); nrst = 1'b1;
  endtask

  // Checks the old value is still held one cycle before the result, then
  // pops the scoreboard at the documented latency.
  task automatic run_and_check(input string name);
    logic [7:0] e;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (outputs !== last_exp) begin
      bad++; $display("FAIL %s_early got=%h exp=%h", name, outputs, last_exp);
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (outputs !== e) begin
      bad++; $display("FAIL %s got=%h exp=%h", name, outputs, e);
    end
    last_exp = e;
  endtask

  task automatic test_basic();
    drive(1, 1, 1, 8'h10, 8'h10, 8'h10);
    exp_q.push_back(8'h30);
    run_and_check("basic");
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (outputs !== 8'h30) begin
      bad++; $display("FAIL basic_hold got=%h exp=30", outputs);
    end
  endtask

  task automatic test_load_only();
    drive(0, 0, 1, 8'h10, 8'h08, 8'h10);
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (outputs !== last_exp) begin
      bad++; $display("FAIL load_only_hold got=%h exp=%h", outputs, last_exp);
    end
    // x stays 0.5 from before; w=0.25 -> layer0 0.75, layer1 0.875
    drive(1, 0, 0, 8'h00, 8'h00, 8'h00);
    exp_q.push_back(8'h1C);
    run_and_check("load_only");
  endtask

  task automatic test_async_reset();
    drive(1, 1, 1, 8'h10, 8'h10, 8'h10);
    @(posedge clk); #2;
    nrst = 1'b0;
    #1;
    total++;
    if (outputs !== 8'h00) begin
      bad++; $display("FAIL async_reset got=%h exp=00", outputs);
    end
    #4; nrst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (outputs !== 8'h00) begin
      bad++; $display("FAIL async_reset_noresult got=%h exp=00", outputs);
    end
    last_exp = 8'h00;
  endtask

  task automatic test_negative();
    drive(1, 1, 1, 8'h10, 8'h10, 8'h10);
    exp_q.push_back(8'h30);
    run_and_check("neg_setup");
    drive(1, 1, 1, 8'h10, 8'hF0, 8'h00);
    exp_q.push_back(8'h00);
    run_and_check("negative");
  endtask

  task automatic test_saturation();
    drive(1, 1, 1, 8'h7F, 8'h7F, 8'h7F);
    exp_q.push_back(8'h7F);
    run_and_check("saturation");
  endtask

  task automatic test_restart();
    drive(1, 1, 1, 8'h10, 8'h10, 8'h10);
    repeat (2) @(posedge clk);
    drive(1, 1, 0, 8'h20, 8'h00, 8'h00);
    exp_q.push_back(8'h40);
    run_and_check("restart");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int xa[N];
      int wa[M-1][N][N];
      int ba[M-1][N];
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        x[k] = 8'($urandom);
        xa[k] = int'($signed(x[k]));
      end
      for (int l = 0; l < M - 1; l++)
        for (int j = 0; j < N; j++) begin
          b[l][j] = 8'($urandom);
          ba[l][j] = int'($signed(b[l][j]));
          for (int k = 0; k < N; k++) begin
            w[l][j][k] = 8'($urandom);
            wa[l][j][k] = int'($signed(w[l][j][k]));
          end
        end
      init = 1'b1; initial_flag = 1'b1; weight_flag = 1'b1;
      exp_q.push_back(8'(model(xa, wa, ba)));
      @(posedge clk); #1;
      init = 1'b0; initial_flag = 1'b0; weight_flag = 1'b0;
      run_and_check("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_only();
    test_async_reset();
    test_negative();
    test_saturation();
    test_restart();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
